fetch_stage: RTL
================

# fetch_stage

Fetch stage of the pipelined RV32 core. Holds the program counter, presents it to instruction memory, and predicts the next PC through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It drives InstrF, PCF, PCPlus4F and PredictTakenF into the Fetch/Decode pipeline register. It accepts branch-resolution updates and mispredict redirects from Execute.

## Interface
- DATA_WIDTH, 32, address/instruction width.
- BTB_ENTRIES, 16, number of BTB entries; must be a power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StallF  in  1  hazard unit hold: PC is not advanced.
- InstrRdata  in  DATA_WIDTH  instruction word returned by instruction memory for address PCF (combinational read).
- UpdateE  in  1  a branch/jump resolved in Execute this cycle.
- PCE  in  DATA_WIDTH  PC of the resolved instruction.
- TakenE  in  1  actual outcome of the resolved instruction.
- TargetE  in  DATA_WIDTH  actual taken target of the resolved instruction.
- MispredictE  in  1  redirect request.
- RedirectPCE  in  DATA_WIDTH  correct next PC when MispredictE is asserted.
- PCF  out  DATA_WIDTH  current fetch PC (registered); also the imem address.
- InstrF  out  DATA_WIDTH  equal to InstrRdata.
- PCPlus4F  out  DATA_WIDTH  PCF + 4, modulo 2^DATA_WIDTH.
- PredictTakenF  out  1  the BTB predicts that the instruction at PCF is taken.

## Operation
- **Lookup fields:**
  - idx = PCF[IDX_W+1:2].
  - tag = PCF[DATA_WIDTH-1:IDX_W+2].
  - PCF[1:0] is ignored.
- **Entry state:** each entry holds valid (1 bit), tag, target (DATA_WIDTH bits) and ctr (2 bits).
- **Prediction:**
  - hit = valid[idx] && tag[idx] == tag.
  - PredictTakenF = hit && ctr[idx][1].
  - PredTarget = target[idx].
- **Next-PC priority (highest first):**
  1. rst → RESET_PC.
  2. MispredictE → RedirectPCE. This overrides StallF.
  3. StallF → PCF (hold).
  4. PredictTakenF → PredTarget.
  5. Otherwise → PCPlus4F.
- **BTB update:** applied on the edge where UpdateE = 1 and rst = 0. Index and tag are taken from PCE. The update is applied regardless of StallF or MispredictE.
  - TakenE = 1, entry hits:
    - ctr ← sat_inc(ctr).
    - target ← TargetE.
  - TakenE = 1, entry misses (allocate or replace):
    - valid ← 1.
    - tag ← PCE tag.
    - target ← TargetE.
    - ctr ← 2'b10 (weakly taken).
  - TakenE = 0, entry hits: ctr ← sat_dec(ctr).
  - TakenE = 0, entry misses: no change. Not-taken branches are never allocated.
- **Saturation:** 2'b11 + 1 stays 2'b11; 2'b00 − 1 stays 2'b00.
- **Reset:**
  - PCF = RESET_PC.
  - All valid = 0, all ctr = 2'b01.
  - Tag and target are don't-care while valid = 0.
  - Therefore after reset: PredictTakenF = 0 and PCPlus4F = RESET_PC + 4.
- **Reset mid-operation:** rst overrides MispredictE, StallF and UpdateE in the same cycle. All state returns to reset values.

## Timing
- PCF is a register. PCPlus4F, PredictTakenF and InstrF are combinational from PCF, BTB state and InstrRdata, all within the same cycle.
- Fetch-to-fetch latency is 1 cycle: one new PC per cycle when unstalled.
- **Redirect:** MispredictE sampled high at edge N → PCF = RedirectPCE immediately after edge N. Squashing the wrong-path F/D contents is the pipeline register's job (its clr input); this block does not do it.
- **Simultaneous update and lookup on the same index:** the lookup in cycle N uses the pre-update entry. The write is visible from cycle N+1.
- **Stall:** holds PCF. BTB updates still occur, so PredictTakenF may change while PCF is held.
- **Wrap-around:** PCF = 32'hFFFF_FFFC gives PCPlus4F = 32'h0000_0000.

## Test plan
- **Reset and sequential fetch:** rst for 2 cycles with RESET_PC = 0, then no stimulus → PCF runs 0, 4, 8, 12; PredictTakenF = 0 throughout.
- **BTB training:**
  - Steps:
    1. UpdateE, PCE = 0x40, TakenE = 1, TargetE = 0x100.
    2. Later, PCF reaches 0x40.
  - Required response:
    - PredictTakenF = 1 (ctr = 10).
    - Next PCF = 0x100.
  - Follow-up: two not-taken updates for PCE = 0x40 → ctr 10→01→00, PredictTakenF = 0 at 0x40, PCF advances to 0x44.
- **Saturation:** five taken updates for PCE = 0x40 → ctr stays 11; then one not-taken update → ctr = 10, still predicts taken.
- **Redirect over stall:** StallF = 1 and MispredictE = 1 with RedirectPCE = 0x200 in the same cycle → PCF = 0x200 on the next cycle. With StallF = 1 alone, PCF is held.
- **Tag aliasing:**
  - Setup: train PCE = 0x40 taken; BTB_ENTRIES = 16, so 0x440 has the same idx and a different tag.
  - Fetch 0x440 → PredictTakenF = 0.
  - Taken update for PCE = 0x440 with target 0x500 → replaces the entry (ctr = 10); fetch at 0x40 then misses.
- **Same-cycle update/lookup, then reset:**
  - PCF = 0x40 in the cycle of the first taken update for 0x40 → PredictTakenF = 0 that cycle.
  - Then assert rst while MispredictE = 1 → PCF = 0 and all entries invalid.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch PC register with direct-mapped BTB prediction; PCF registered, outputs combinational from PCF (1-cycle fetch).
// StallF holds PCF (MispredictE still redirects); BTB updates from Execute are applied regardless of stall.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic [DATA_WIDTH-1:0] InstrRdata,
  input  logic                  UpdateE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic                  TakenE,
  input  logic [DATA_WIDTH-1:0] TargetE,
  input  logic                  MispredictE,
  input  logic [DATA_WIDTH-1:0] RedirectPCE,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  PredictTakenF
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]      f_idx, e_idx;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic                  f_hit, e_hit;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  unused_pce_bits;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[DATA_WIDTH-1:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[DATA_WIDTH-1:IDX_W+2];
  assign unused_pce_bits = ^PCE[1:0];

  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit         = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign PredictTakenF = f_hit && ctr_q[f_idx][1];
  assign PCPlus4F      = PCF + DATA_WIDTH'(4);
  assign InstrF        = InstrRdata;

  // Redirect from Execute wins over the hazard-unit stall.
  always_comb begin
    pc_next = PCPlus4F;
    if (MispredictE)        pc_next = RedirectPCE;
    else if (StallF)        pc_next = PCF;
    else if (PredictTakenF) pc_next = target_q[f_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) PCF <= RESET_PC;
    else     PCF <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (UpdateE) begin
      if (TakenE) begin
        valid_q[e_idx] <= 1'b1;
        if (e_hit) ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
        else       ctr_q[e_idx] <= 2'b10;
      end else if (e_hit) begin
        ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
      end
    end
  end

  // Tag and target are meaningless while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && UpdateE && TakenE) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= TargetE;
    end
  end

endmodule
